// File: rtl/chunked_adder_unit_if.sv
// chunked_adder_unit_if
// Operand/result bundle and Start/Busy/Done handshake for chunked_adder_unit.
//   Rs, Rd  : operands A and B
//   Mode    : 00 ADD, 01 ADC, 10 SUB, 11 INC
//   Start   : request, honoured only while the unit is idle
//   Busy    : operation in flight
//   Done    : one-cycle pulse when Out/Ccr are updated
//   Out     : registered result
//   Ccr     : registered flags {C, N, Z}
// master = requester (execute-stage controller), slave = adder unit.
interface chunked_adder_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Rs;
  logic [WIDTH-1:0] Rd;
  logic [1:0]       Mode;
  logic             Start;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;
  logic [2:0]       Ccr;

  modport master (
    output Rs, Rd, Mode, Start,
    input  Busy, Done, Out, Ccr
  );

  modport slave (
    input  Rs, Rd, Mode, Start,
    output Busy, Done, Out, Ccr
  );
endinterface

// File: rtl/chunked_adder_unit.sv
// chunked_adder_unit
// Multi-cycle add/subtract unit: adds two WIDTH-bit operands CHUNK bits per
// cycle, rippling the carry between slices, then updates Out and Ccr.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : chunked_adder_unit_if slave (Rs, Rd, Mode, Start in;
//          Busy, Done, Out, Ccr out)
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for Start; Out/Ccr hold the last result
// S_BUSY | one slice per cycle, r_idx = slice in progress (0..N-1)
module chunked_adder_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  chunked_adder_unit_if.slave  bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_partial;
  logic [WIDTH-1:0] r_out;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_sub;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_ccr;

  int               w_off;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_last;
  logic             w_c_flag;

  always_comb begin
    w_off    = int'(r_idx) * CHUNK;
    w_sum    = {1'b0, r_a[w_off +: CHUNK]} + {1'b0, r_b[w_off +: CHUNK]}
             + {{CHUNK{1'b0}}, r_carry};
    // Partial result with the current slice merged in, so the final cycle
    // can load Out directly without an extra write-back cycle.
    w_result = r_partial;
    w_result[w_off +: CHUNK] = w_sum[CHUNK-1:0];
    w_last   = (r_idx == IDX_W'(N - 1));
    // SUB is computed as A + ~B + 1; its carry-out is the inverse of borrow.
    w_c_flag = r_sub ? ~w_sum[CHUNK] : w_sum[CHUNK];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_partial <= '0;
      r_out     <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_sub     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ccr     <= 3'b000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_a       <= bus.Rs;
            r_idx     <= '0;
            r_partial <= '0;
            r_sub     <= (bus.Mode == 2'b10);
            r_busy    <= 1'b1;
            r_state   <= S_BUSY;
            case (bus.Mode)
              2'b00: begin
                r_b     <= bus.Rd;
                r_carry <= 1'b0;
              end
              2'b01: begin
                // r_ccr here already reflects a result completed on the
                // previous edge, so chained ADC in the Done cycle works.
                r_b     <= bus.Rd;
                r_carry <= r_ccr[2];
              end
              2'b10: begin
                r_b     <= ~bus.Rd;
                r_carry <= 1'b1;
              end
              default: begin
                r_b     <= '0;
                r_carry <= 1'b1;
              end
            endcase
          end
        end
        S_BUSY: begin
          r_partial <= w_result;
          r_carry   <= w_sum[CHUNK];
          if (w_last) begin
            r_out   <= w_result;
            r_ccr   <= {w_c_flag, w_result[WIDTH-1], (w_result == '0)};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Out  = r_out;
  assign bus.Ccr  = r_ccr;
endmodule

// File: tb/tb_chunked_adder_unit.sv
// tb_chunked_adder_unit
// Directed bench for chunked_adder_unit: a 16/4 instance checked every cycle
// against a transaction-level model, plus 32/8 and 32/32 instances for the
// parameter sweep. Literal expectations pin both model and DUT.
module tb_chunked_adder_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chunked_adder_unit_if #(.WIDTH(16)) bus16 ();
  chunked_adder_unit_if #(.WIDTH(32)) bus32a ();
  chunked_adder_unit_if #(.WIDTH(32)) bus32b ();

  chunked_adder_unit #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave));
  chunked_adder_unit #(.WIDTH(32), .CHUNK(8)) dut32_8 (
    .clk(clk), .rst(rst), .bus(bus32a.slave));
  chunked_adder_unit #(.WIDTH(32), .CHUNK(32)) dut32_32 (
    .clk(clk), .rst(rst), .bus(bus32b.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no Done within bound, expected one", name);
  endtask

  // Transaction-level model: result from plain arithmetic, timing as a
  // count of N busy cycles after acceptance.
  localparam int N16 = 4;

  function automatic logic [18:0] model_op(input logic [15:0] rs,
                                           input logic [15:0] rd,
                                           input logic [1:0] mode,
                                           input logic cin);
    logic [16:0] full;
    logic [15:0] r;
    logic        c;
    case (mode)
      2'd0:    full = {1'b0, rs} + {1'b0, rd};
      2'd1:    full = {1'b0, rs} + {1'b0, rd} + {16'd0, cin};
      2'd2:    full = {1'b0, rs - rd};
      default: full = {1'b0, rs} + 17'd1;
    endcase
    r = full[15:0];
    c = (mode == 2'd2) ? (rs < rd) : full[16];
    return {c, r[15], (r == 16'd0), r};
  endfunction

  logic [15:0] m_out, m_pend_out;
  logic [2:0]  m_ccr, m_pend_ccr;
  logic        m_busy, m_done;
  int          m_cnt;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_out  <= '0;
      m_ccr  <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_out  <= m_pend_out;
          m_ccr  <= m_pend_ccr;
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (bus16.Start) begin
        {m_pend_ccr, m_pend_out} <= model_op(bus16.Rs, bus16.Rd, bus16.Mode, m_ccr[2]);
        m_busy <= 1'b1;
        m_cnt  <= N16;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cmp_busy", 32'(bus16.Busy), 32'(m_busy));
      check("cmp_done", 32'(bus16.Done), 32'(m_done));
      check("cmp_out",  32'(bus16.Out),  32'(m_out));
      check("cmp_ccr",  32'(bus16.Ccr),  32'(m_ccr));
    end
  end

  // Issue one op on the 16-bit unit and return Start-to-Done latency.
  // now=1 drives Start in the current cycle (used in a Done cycle).
  task automatic run_op(input logic [15:0] rs, input logic [15:0] rd,
                        input logic [1:0] mode, input bit now,
                        output int lat);
    if (!now) @(negedge clk);
    bus16.Rs = rs; bus16.Rd = rd; bus16.Mode = mode; bus16.Start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus16.Start = 1'b0;
      if (bus16.Done === 1'b1) begin
        lat = i;
        return;
      end
    end
    timeout("run_op_done");
    lat = -1;
  endtask

  int lat, ndone, la, lb;
  logic [31:0] oa, ob;
  logic [2:0]  ca, cb;

  initial begin
    bus16.Rs = '0; bus16.Rd = '0; bus16.Mode = '0; bus16.Start = 1'b0;
    bus32a.Rs = '0; bus32a.Rd = '0; bus32a.Mode = '0; bus32a.Start = 1'b0;
    bus32b.Rs = '0; bus32b.Rd = '0; bus32b.Mode = '0; bus32b.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_out",  32'(bus16.Out),  32'h0);
    check("reset_ccr",  32'(bus16.Ccr),  32'h0);
    check("reset_busy", 32'(bus16.Busy), 32'h0);

    // ADD wrap
    run_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, lat);
    check("add_wrap_lat", 32'(lat), 32'd5);
    check("add_wrap_out", 32'(bus16.Out), 32'h0000);
    check("add_wrap_ccr", 32'(bus16.Ccr), 32'b101);

    // ADC chained in the Done cycle, carry-in 1
    run_op(16'h0001, 16'h0002, 2'b01, 1'b1, lat);
    check("adc_chain_lat", 32'(lat), 32'd5);
    check("adc_chain_out", 32'(bus16.Out), 32'h0004);
    check("adc_chain_ccr", 32'(bus16.Ccr), 32'b000);

    // ADC with carry-in 0, carry rippling across slices
    run_op(16'h00F0, 16'h0010, 2'b01, 1'b0, lat);
    check("adc_c0_out", 32'(bus16.Out), 32'h0100);
    check("adc_c0_ccr", 32'(bus16.Ccr), 32'b000);

    // SUB borrow, then equal operands
    run_op(16'h0003, 16'h0005, 2'b10, 1'b0, lat);
    check("sub_borrow_out", 32'(bus16.Out), 32'hFFFE);
    check("sub_borrow_ccr", 32'(bus16.Ccr), 32'b110);
    run_op(16'h0005, 16'h0005, 2'b10, 1'b0, lat);
    check("sub_eq_out", 32'(bus16.Out), 32'h0000);
    check("sub_eq_ccr", 32'(bus16.Ccr), 32'b001);

    // Reset mid-BUSY of an ADD: discarded, no Done
    @(negedge clk);
    bus16.Rs = 16'h1234; bus16.Rd = 16'h1111; bus16.Mode = 2'b00; bus16.Start = 1'b1;
    @(negedge clk);
    bus16.Start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_out",  32'(bus16.Out),  32'h0);
    check("abort_ccr",  32'(bus16.Ccr),  32'h0);
    check("abort_busy", 32'(bus16.Busy), 32'h0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus16.Done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // INC with Start pulse and operand changes during BUSY
    @(negedge clk);
    bus16.Rs = 16'h7FFF; bus16.Rd = 16'hAAAA; bus16.Mode = 2'b11; bus16.Start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) bus16.Start = 1'b0;
      if (i == 1) begin
        bus16.Rs = 16'h1234; bus16.Rd = 16'hFFFF; bus16.Mode = 2'b00; bus16.Start = 1'b1;
      end
      if (i == 2) bus16.Start = 1'b0;
      if (bus16.Done === 1'b1) ndone++;
    end
    check("inc_one_done", 32'(ndone), 32'd1);
    check("inc_out", 32'(bus16.Out), 32'h8000);
    check("inc_ccr", 32'(bus16.Ccr), 32'b010);

    // Parameter sweep: 32/8 (N=4) and 32/32 (N=1) started together
    @(negedge clk);
    bus32a.Rs = 32'h0000FFFF; bus32a.Rd = 32'h1; bus32a.Mode = 2'b00; bus32a.Start = 1'b1;
    bus32b.Rs = 32'h0000FFFF; bus32b.Rd = 32'h1; bus32b.Mode = 2'b00; bus32b.Start = 1'b1;
    la = 0; lb = 0; oa = '0; ob = '0; ca = '0; cb = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus32a.Start = 1'b0;
        bus32b.Start = 1'b0;
        check("n1_busy", 32'(bus32b.Busy), 32'd1);
      end
      if (bus32a.Done === 1'b1 && la == 0) begin la = i; oa = bus32a.Out; ca = bus32a.Ccr; end
      if (bus32b.Done === 1'b1 && lb == 0) begin lb = i; ob = bus32b.Out; cb = bus32b.Ccr; end
    end
    if (la == 0) timeout("w32c8_done");
    else begin
      check("w32c8_lat", 32'(la), 32'd5);
      check("w32c8_out", oa, 32'h00010000);
      check("w32c8_ccr", 32'(ca), 32'b000);
    end
    if (lb == 0) timeout("w32c32_done");
    else begin
      check("w32c32_lat", 32'(lb), 32'd2);
      check("w32c32_out", ob, 32'h00010000);
      check("w32c32_ccr", 32'(cb), 32'b000);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
